// File: rtl/tx_symbol_upsampler.sv
// TX symbol upsampler: buffers BPSK bits, maps them to +/-AMP and
// zero-stuffs by OS to feed the TX polyphase FIR.
module tx_symbol_upsampler #(
    parameter int OS         = 4,
    parameter int DW         = 8,
    parameter int AMP        = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_sym_valid,
    input  logic                       i_sym,
    output logic                       o_sym_ready,
    output logic signed [DW-1:0]       o_os_data,
    output logic                       o_os_valid,
    output logic [$clog2(OS)-1:0]      o_phase,
    output logic                       o_underflow
);

    localparam int PW = $clog2(OS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic signed [DW-1:0] AMP_POS = DW'(AMP);
    localparam logic signed [DW-1:0] AMP_NEG = DW'(-AMP);
    localparam logic [PW-1:0]        PH_LAST = PW'(OS - 1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [PW-1:0]         phase_cnt;

    logic fifo_empty;
    logic push;
    logic pop;
    logic head;
    logic sym_tick;

    always_comb begin
        o_sym_ready = (count != CNT_FULL);
        fifo_empty  = (count == '0);
        push        = i_sym_valid && o_sym_ready;
        sym_tick    = i_enable && (phase_cnt == '0);
        // Pop sees only registered count, so a same-cycle push is invisible
        pop         = sym_tick && !fifo_empty;
        head        = mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= i_sym;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            phase_cnt   <= '0;
            o_os_data   <= '0;
            o_os_valid  <= 1'b0;
            o_phase     <= '0;
            o_underflow <= 1'b0;
        end else if (i_enable) begin
            o_os_valid <= 1'b1;
            o_phase    <= phase_cnt;
            phase_cnt  <= (phase_cnt == PH_LAST) ? '0 : phase_cnt + 1'b1;
            if (phase_cnt == '0) begin
                if (!fifo_empty) begin
                    o_os_data <= head ? AMP_NEG : AMP_POS;
                end else begin
                    o_os_data   <= '0;
                    o_underflow <= 1'b1;
                end
            end else begin
                o_os_data <= '0;
            end
        end else begin
            o_os_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_symbol_upsampler.sv
// Self-checking bench for tx_symbol_upsampler against a queue-based
// reference model of the symbol stream.
module tb_tx_symbol_upsampler;

    localparam int OS = 4;
    localparam int DW = 8;
    localparam int AMP = 64;
    localparam int D = 4;
    localparam logic signed [DW-1:0] AP = 8'sd64;
    localparam logic signed [DW-1:0] AN = -8'sd64;

    logic                 clock = 1'b0;
    logic                 i_reset;
    logic                 i_enable;
    logic                 i_sym_valid;
    logic                 i_sym;
    logic                 o_sym_ready;
    logic signed [DW-1:0] o_os_data;
    logic                 o_os_valid;
    logic [1:0]           o_phase;
    logic                 o_underflow;

    always #5 clock = ~clock;

    tx_symbol_upsampler #(
        .OS(OS), .DW(DW), .AMP(AMP), .FIFO_DEPTH(D)
    ) dut (
        .clock(clock),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_sym_valid(i_sym_valid),
        .i_sym(i_sym),
        .o_sym_ready(o_sym_ready),
        .o_os_data(o_os_data),
        .o_os_valid(o_os_valid),
        .o_phase(o_phase),
        .o_underflow(o_underflow)
    );

    int checks = 0;
    int failures = 0;

    logic                 mq[$];
    int                   mphase;
    logic signed [DW-1:0] exp_data;
    logic                 exp_valid;
    logic [1:0]           exp_phase;
    logic                 exp_und;
    logic                 exp_ready;
    logic                 rdy_obs;

    task automatic model_clear();
        mq.delete();
        mphase    = 0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_phase = '0;
        exp_und   = 1'b0;
    endtask

    // One clock: drive inputs, advance model, return sampled outputs
    task automatic step(input logic en, input logic v, input logic s,
                        output logic acc);
        logic b;
        i_enable = en;
        i_sym_valid = v;
        i_sym = s;
        #1;
        rdy_obs = o_sym_ready;
        exp_ready = (mq.size() < D);
        acc = v && exp_ready;
        if (en) begin
            exp_valid = 1'b1;
            exp_phase = 2'(mphase);
            if (mphase == 0) begin
                if (mq.size() > 0) begin
                    b = mq.pop_front();
                    exp_data = b ? AN : AP;
                end else begin
                    exp_data = '0;
                    exp_und = 1'b1;
                end
            end else begin
                exp_data = '0;
            end
            mphase = (mphase + 1) % OS;
        end else begin
            exp_valid = 1'b0;
        end
        if (acc) mq.push_back(s);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_enable = 1'b1;
        i_sym_valid = 1'b1;
        i_sym = 1'b1;
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        i_enable = 1'b0;
        i_sym_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (o_os_data !== 8'sd0 || o_os_valid !== 1'b0 || o_phase !== 2'd0
            || o_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got d=%0d v=%b p=%0d u=%b req 0/0/0/0",
                     o_os_data, o_os_valid, o_phase, o_underflow);
        end
        checks++;
        if (o_sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b req=1", o_sym_ready);
        end
    endtask

    task automatic test_basic_seq();
        int t1[16] = '{-64, 0, 0, 0, 64, 0, 0, 0, -64, 0, 0, 0, -64, 0, 0, 0};
        logic bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic acc;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, bits[k], acc);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, acc);
            checks++;
            if (int'(o_os_data) !== t1[i] || o_phase !== 2'(i % 4)
                || o_underflow !== 1'b0 || o_os_valid !== 1'b1) begin
                failures++;
                $display("FAIL basic[%0d] got d=%0d p=%0d u=%b v=%b req d=%0d p=%0d u=0 v=1",
                         i, o_os_data, o_phase, o_underflow, o_os_valid, t1[i], i % 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic s[5];
        logic acc;
        do_reset();
        for (int k = 0; k < 5; k++) s[k] = 1'($urandom_range(1));
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, s[k], acc);
            checks++;
            if (rdy_obs !== (k < 4)) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%b req=%b", k, rdy_obs, k < 4);
            end
        end
        step(1'b1, 1'b1, s[4], acc);
        checks++;
        if (rdy_obs !== 1'b0 || o_os_data !== (s[0] ? AN : AP)) begin
            failures++;
            $display("FAIL b2b_pop_cycle got rdy=%b d=%0d req rdy=0 d=%0d",
                     rdy_obs, o_os_data, s[0] ? AN : AP);
        end
        step(1'b0, 1'b1, s[4], acc);
        checks++;
        if (rdy_obs !== 1'b1) begin
            failures++;
            $display("FAIL b2b_fifth_accept got=%b req=1", rdy_obs);
        end
        for (int j = 1; j < 17; j++) begin
            step(1'b1, 1'b0, 1'b0, acc);
            if (j % 4 == 0) begin
                checks++;
                if (o_os_data !== (s[j / 4] ? AN : AP) || o_phase !== 2'd0) begin
                    failures++;
                    $display("FAIL b2b_sym[%0d] got d=%0d p=%0d req d=%0d p=0",
                             j / 4, o_os_data, o_phase, s[j / 4] ? AN : AP);
                end
            end
        end
    endtask

    task automatic test_underflow();
        logic acc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, acc);
            checks++;
            if (o_os_data !== 8'sd0 || o_underflow !== 1'b1) begin
                failures++;
                $display("FAIL undf_empty[%0d] got d=%0d u=%b req d=0 u=1",
                         i, o_os_data, o_underflow);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i < 3, 1'($urandom_range(1)), acc);
            checks++;
            if (o_os_data !== exp_data || o_underflow !== 1'b1) begin
                failures++;
                $display("FAIL undf_sticky[%0d] got d=%0d u=%b req d=%0d u=1",
                         i, o_os_data, o_underflow, exp_data);
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic en_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   d_req[4] = '{64, 64, 0, 0};
        int   p_req[4] = '{0, 0, 1, 1};
        int   npos = 0;
        logic acc;
        do_reset();
        step(1'b0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            step(en_seq[i], 1'b0, 1'b0, acc);
            if (o_os_valid && o_os_data == AP) npos++;
            checks++;
            if (o_os_valid !== en_seq[i] || int'(o_os_data) !== d_req[i]
                || int'(o_phase) !== p_req[i]) begin
                failures++;
                $display("FAIL en_toggle[%0d] got v=%b d=%0d p=%0d req v=%b d=%0d p=%0d",
                         i, o_os_valid, o_os_data, o_phase, en_seq[i], d_req[i], p_req[i]);
            end
        end
        checks++;
        if (npos != 1) begin
            failures++;
            $display("FAIL en_toggle_once got=%0d req=1", npos);
        end
    endtask

    task automatic test_mid_reset();
        logic acc;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'($urandom_range(1)), acc);
        step(1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 1'b0, acc);
        do_reset();
        #1;
        checks++;
        if (o_os_data !== 8'sd0 || o_os_valid !== 1'b0 || o_phase !== 2'd0
            || o_underflow !== 1'b0 || o_sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_outputs got d=%0d v=%b p=%0d u=%b r=%b req 0/0/0/0/1",
                     o_os_data, o_os_valid, o_phase, o_underflow, o_sym_ready);
        end
        step(1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, acc);
        checks++;
        if (o_os_data !== AN || o_phase !== 2'd0 || o_os_valid !== 1'b1
            || o_underflow !== 1'b0) begin
            failures++;
            $display("FAIL midrst_first got d=%0d p=%0d v=%b u=%b req d=-64 p=0 v=1 u=0",
                     o_os_data, o_phase, o_os_valid, o_underflow);
        end
    endtask

    task automatic test_sustained();
        logic bits[1000];
        logic rx[$];
        logic acc;
        int   bad = 0;
        for (int n = 0; n < 1000; n++) bits[n] = 1'($urandom_range(1));
        do_reset();
        step(1'b0, 1'b1, bits[0], acc);
        for (int t = 0; t < 999 * OS + OS; t++) begin
            int  n = t / OS + 1;
            logic v = (t % OS == 0) && (n < 1000);
            step(1'b1, v, v ? bits[n] : 1'b0, acc);
            if (v) begin
                checks++;
                if (rdy_obs !== 1'b1) begin
                    failures++;
                    $display("FAIL sust_ready[%0d] got=%b req=1", n, rdy_obs);
                end
            end
            if (o_os_valid && o_phase == 2'd0) rx.push_back(o_os_data < 0);
            if (o_underflow !== 1'b0 || o_os_data !== exp_data) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sust_stream got=%0d bad_cycles req=0", bad);
        end
        checks++;
        if (rx.size() != 1000) begin
            failures++;
            $display("FAIL sust_count got=%0d req=1000", rx.size());
        end else begin
            for (int n = 0; n < 1000; n++) begin
                checks++;
                if (rx[n] !== bits[n]) begin
                    failures++;
                    $display("FAIL sust_sign[%0d] got=%b req=%b", n, rx[n], bits[n]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic acc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                 1'($urandom_range(1)), acc);
            checks++;
            if (rdy_obs !== exp_ready || o_os_data !== exp_data
                || o_os_valid !== exp_valid || o_underflow !== exp_und
                || (exp_valid && o_phase !== exp_phase)) begin
                failures++;
                $display("FAIL rand[%0d] got r=%b d=%0d v=%b p=%0d u=%b req r=%b d=%0d v=%b p=%0d u=%b",
                         i, rdy_obs, o_os_data, o_os_valid, o_phase, o_underflow,
                         exp_ready, exp_data, exp_valid, exp_phase, exp_und);
            end
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_enable = 1'b0;
        i_sym_valid = 1'b0;
        i_sym = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        test_reset();
        test_basic_seq();
        test_back_to_back();
        test_underflow();
        test_enable_toggle();
        test_mid_reset();
        test_sustained();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
